execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The block SHALL have exactly one clock domain, and reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all output registers.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 adder_in  input  16  incremented PC (PC+1) from decode.
REQ-005 regfile_read_data_1_in  input  16  rs operand; ALU operand A.
REQ-006 regfile_read_data_2_in  input  16  rt operand; ALU operand B when ALUSrc_in=0.
REQ-007 sign_extended_input  input  16  sign-extended immediate; bits [2:0] are the R-type funct field.
REQ-008 rt_in  input  3  rt register index.
REQ-009 rd_in  input  3  rd register index.
REQ-010 RegDst_in  input  1  1 selects rd_in as destination, 0 selects rt_in.
REQ-011 ALUSrc_in  input  1  1 selects sign_extended_input as operand B, 0 selects regfile_read_data_2_in.
REQ-012 ALUOp_in  input  2  ALU operation class.
REQ-013 ALU_Result  output  16  registered ALU result.
REQ-014 adder_out  output  16  registered branch target.
REQ-015 Zero  output  1  registered flag; 1 when the ALU result equals 0.
REQ-016 mux_rd_rt_output  output  3  registered destination register index.

Function
REQ-017 Operand B SHALL be sign_extended_input when ALUSrc_in=1, else regfile_read_data_2_in.
REQ-018 ALUOp_in=00 SHALL compute A+B (load/store address).
REQ-019 ALUOp_in=01 SHALL compute A-B (branch compare).
REQ-020 ALUOp_in=11 SHALL compute A|B (immediate OR).
REQ-021 ALUOp_in=10 SHALL decode funct=sign_extended_input[2:0] as follows: 000 ADD; 001 SUB; 010 AND; 011 OR; 100 XOR; 101 NOR; 110 SLT (signed, result 16'h0001 or 16'h0000); 111 SLL (A shifted left by B[3:0]).
REQ-022 All arithmetic SHALL be 16-bit two's complement, with the result truncated to 16 bits (wrap-around) and no overflow flag or trap.
REQ-023 The branch target SHALL be adder_in + (sign_extended_input << 1), truncated to 16 bits.
REQ-024 The destination index SHALL be rd_in when RegDst_in=1, else rt_in.
REQ-025 On each rising clk edge with rst_n=1, ALU_Result, adder_out, Zero and mux_rd_rt_output SHALL capture the combinational values from the current inputs (latency exactly 1 cycle).
REQ-026 Zero SHALL be registered in the same edge as ALU_Result, computed from the same ALU result (Zero=1 iff result==16'h0000).
REQ-027 There SHALL be no stall or handshake; new inputs SHALL be accepted every cycle, and outputs SHALL hold between edges.
REQ-028 Input changes between clock edges SHALL NOT affect the outputs until the next rising edge.

Reset
REQ-029 When rst_n=0, all outputs SHALL be forced to 0 immediately, independent of clk (ALU_Result=0, adder_out=0, Zero=0, mux_rd_rt_output=0).
REQ-030 While rst_n=0, the outputs SHALL hold 0; the first rising edge after rst_n deasserts SHALL load normal results.
REQ-031 Assertion of reset mid-operation SHALL discard the in-flight result.

Verification
REQ-032 The bench SHALL cover add-immediate: A=0x0005, imm=0x0003, ALUSrc=1, ALUOp=00, RegDst=0, rt=2 -> after one edge ALU_Result=0x0008, Zero=0, dest=2.
REQ-033 The bench SHALL cover branch-equal: A=B=0x1234, ALUSrc=0, ALUOp=01, adder_in=0x0010, imm=0x0004 -> ALU_Result=0, Zero=1, adder_out=0x0018.
REQ-034 The bench SHALL cover the R-type sweep: A=0x00F0, B=0x0F0F, ALUOp=10, RegDst=1, rd=5 -> funct 010=0x0000 with Zero=1; 011=0x0FFF; 100=0x0FFF; 101=0xF000; dest=5 for all.
REQ-035 The bench SHALL cover signed SLT and wrap: A=0xFFFF, B=0x0001, funct 110 -> 0x0001; A=0xFFFF, B=0x0001, ALUOp=00 -> 0x0000 with Zero=1.
REQ-036 The bench SHALL cover a negative branch offset: adder_in=0x0020, imm=0xFFFE -> adder_out=0x001C.
REQ-037 The bench SHALL cover async reset: drive rst_n low between clock edges while outputs are non-zero -> all outputs read 0 before the next edge and remain 0 until an edge with rst_n=1.

Source files
------------

// File: rtl/execute_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | execute_stage_if : operand/control bundle into, and results out of, the   |
// |                    execute pipeline stage.                                |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface execute_stage_if;
  logic [15:0] adder_in;
  logic [15:0] regfile_read_data_1_in;
  logic [15:0] regfile_read_data_2_in;
  logic [15:0] sign_extended_input;
  logic [2:0]  rt_in;
  logic [2:0]  rd_in;
  logic        RegDst_in;
  logic        ALUSrc_in;
  logic [1:0]  ALUOp_in;
  logic [15:0] ALU_Result;
  logic [15:0] adder_out;
  logic        Zero;
  logic [2:0]  mux_rd_rt_output;

  modport master (
    output adder_in, regfile_read_data_1_in, regfile_read_data_2_in,
           sign_extended_input, rt_in, rd_in, RegDst_in, ALUSrc_in, ALUOp_in,
    input  ALU_Result, adder_out, Zero, mux_rd_rt_output
  );

  modport slave (
    input  adder_in, regfile_read_data_1_in, regfile_read_data_2_in,
           sign_extended_input, rt_in, rd_in, RegDst_in, ALUSrc_in, ALUOp_in,
    output ALU_Result, adder_out, Zero, mux_rd_rt_output
  );
endinterface
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | execute_stage : 16-bit ALU, branch-target adder and destination mux with  |
// |                 all results registered (one-cycle latency).               |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module execute_stage (
  input  wire logic      clk,
  input  wire logic      rst_n,
  execute_stage_if.slave ex
);

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [2:0] FUNCT_ADD = 3'b000;
  localparam logic [2:0] FUNCT_SUB = 3'b001;
  localparam logic [2:0] FUNCT_AND = 3'b010;
  localparam logic [2:0] FUNCT_OR  = 3'b011;
  localparam logic [2:0] FUNCT_XOR = 3'b100;
  localparam logic [2:0] FUNCT_NOR = 3'b101;
  localparam logic [2:0] FUNCT_SLT = 3'b110;
  localparam logic [2:0] FUNCT_SLL = 3'b111;

  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [2:0]  funct;

  logic [15:0] alu_result_d, alu_result_q;
  logic [15:0] adder_out_d,  adder_out_q;
  logic        zero_d,       zero_q;
  logic [2:0]  dest_d,       dest_q;

  always_comb begin
    operand_a = ex.regfile_read_data_1_in;
    operand_b = ex.ALUSrc_in ? ex.sign_extended_input : ex.regfile_read_data_2_in;
    funct     = ex.sign_extended_input[2:0];

    alu_result_d = 16'h0000;
    unique case (ex.ALUOp_in)
      ALUOP_ADD: alu_result_d = operand_a + operand_b;
      ALUOP_SUB: alu_result_d = operand_a - operand_b;
      ALUOP_OR:  alu_result_d = operand_a | operand_b;
      ALUOP_RTYPE: begin
        unique case (funct)
          FUNCT_ADD: alu_result_d = operand_a + operand_b;
          FUNCT_SUB: alu_result_d = operand_a - operand_b;
          FUNCT_AND: alu_result_d = operand_a & operand_b;
          FUNCT_OR:  alu_result_d = operand_a | operand_b;
          FUNCT_XOR: alu_result_d = operand_a ^ operand_b;
          FUNCT_NOR: alu_result_d = ~(operand_a | operand_b);
          FUNCT_SLT: alu_result_d = {15'd0, $signed(operand_a) < $signed(operand_b)};
          FUNCT_SLL: alu_result_d = operand_a << operand_b[3:0];
          default:   alu_result_d = 16'h0000;
        endcase
      end
      default: alu_result_d = 16'h0000;
    endcase

    // Zero flag tracks the same result word that is being registered.
    zero_d      = (alu_result_d == 16'h0000);
    adder_out_d = ex.adder_in + {ex.sign_extended_input[14:0], 1'b0};
    dest_d      = ex.RegDst_in ? ex.rd_in : ex.rt_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= 16'h0000;
      adder_out_q  <= 16'h0000;
      zero_q       <= 1'b0;
      dest_q       <= 3'd0;
    end else begin
      alu_result_q <= alu_result_d;
      adder_out_q  <= adder_out_d;
      zero_q       <= zero_d;
      dest_q       <= dest_d;
    end
  end

  assign ex.ALU_Result       = alu_result_q;
  assign ex.adder_out        = adder_out_q;
  assign ex.Zero             = zero_q;
  assign ex.mux_rd_rt_output = dest_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_execute_stage : directed literal checks plus randomized stimulus       |
// |                    compared against an arithmetic reference model.        |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_execute_stage;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   started     = 1'b0;

  logic [15:0] exp_alu;
  logic [15:0] exp_tgt;
  logic        exp_zero;
  logic [2:0]  exp_dest;

  execute_stage_if ex_if ();

  execute_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (ex_if)
  );

  always #5 clk = ~clk;

  // Reference ALU written as plain integer arithmetic modulo 2^16.
  function automatic logic [15:0] model_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] op, input logic [2:0] fn);
    int ua, ub, sa, sb, r;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    r  = 0;
    if (op == 2'd0)      r = ua + ub;
    else if (op == 2'd1) r = ua - ub + 65536;
    else if (op == 2'd3) r = int'(a | b);
    else begin
      if (fn == 3'd0)      r = ua + ub;
      else if (fn == 3'd1) r = ua - ub + 65536;
      else if (fn == 3'd2) r = int'(a & b);
      else if (fn == 3'd3) r = int'(a | b);
      else if (fn == 3'd4) r = int'(a ^ b);
      else if (fn == 3'd5) r = 65535 - int'(a | b);
      else if (fn == 3'd6) r = (sa < sb) ? 1 : 0;
      else                 r = ua * (2 ** int'(b[3:0]));
    end
    return 16'(r % 65536);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_alu  <= 16'h0;
      exp_tgt  <= 16'h0;
      exp_zero <= 1'b0;
      exp_dest <= 3'd0;
    end else begin
      logic [15:0] b, r;
      b = ex_if.ALUSrc_in ? ex_if.sign_extended_input : ex_if.regfile_read_data_2_in;
      r = model_alu(ex_if.regfile_read_data_1_in, b, ex_if.ALUOp_in,
                    ex_if.sign_extended_input[2:0]);
      exp_alu  <= r;
      exp_zero <= (r == 16'h0);
      exp_tgt  <= 16'((int'(ex_if.adder_in) + 2 * int'(ex_if.sign_extended_input)) % 65536);
      exp_dest <= ex_if.RegDst_in ? ex_if.rd_in : ex_if.rt_in;
    end
  end

  always @(posedge clk) started <= 1'b1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("sb_alu",  ex_if.ALU_Result, exp_alu);
      check("sb_tgt",  ex_if.adder_out,  exp_tgt);
      check("sb_zero", {15'd0, ex_if.Zero}, {15'd0, exp_zero});
      check("sb_dest", {13'd0, ex_if.mux_rd_rt_output}, {13'd0, exp_dest});
    end
  end

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                       input logic [15:0] pc, input logic [2:0] rt, input logic [2:0] rd,
                       input logic regdst, input logic alusrc, input logic [1:0] op);
    ex_if.regfile_read_data_1_in = a;
    ex_if.regfile_read_data_2_in = b;
    ex_if.sign_extended_input    = imm;
    ex_if.adder_in               = pc;
    ex_if.rt_in                  = rt;
    ex_if.rd_in                  = rd;
    ex_if.RegDst_in              = regdst;
    ex_if.ALUSrc_in              = alusrc;
    ex_if.ALUOp_in               = op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_alu"},  ex_if.ALU_Result, 16'h0);
    check({name, "_tgt"},  ex_if.adder_out,  16'h0);
    check({name, "_zero"}, {15'd0, ex_if.Zero}, 16'h0);
    check({name, "_dest"}, {13'd0, ex_if.mux_rd_rt_output}, 16'h0);
  endtask

  logic [2:0]  rfunct [4] = '{3'b010, 3'b011, 3'b100, 3'b101};
  logic [15:0] rexp   [4] = '{16'h0000, 16'h0FFF, 16'h0FFF, 16'hF000};

  initial begin
    drive(16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 2'd0);
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Add-immediate
    drive(16'h0005, 16'hAAAA, 16'h0003, 16'h0000, 3'd2, 3'd7, 1'b0, 1'b1, 2'b00);
    step();
    check("addi_alu",  ex_if.ALU_Result, 16'h0008);
    check("addi_zero", {15'd0, ex_if.Zero}, 16'h0);
    check("addi_dest", {13'd0, ex_if.mux_rd_rt_output}, 16'd2);

    // Branch-equal
    drive(16'h1234, 16'h1234, 16'h0004, 16'h0010, 3'd1, 3'd3, 1'b0, 1'b0, 2'b01);
    step();
    check("beq_alu",  ex_if.ALU_Result, 16'h0000);
    check("beq_zero", {15'd0, ex_if.Zero}, 16'h1);
    check("beq_tgt",  ex_if.adder_out, 16'h0018);

    // R-type sweep
    for (int i = 0; i < 4; i++) begin
      drive(16'h00F0, 16'h0F0F, {13'd0, rfunct[i]}, 16'h0, 3'd1, 3'd5, 1'b1, 1'b0, 2'b10);
      step();
      check("rtype_alu",  ex_if.ALU_Result, rexp[i]);
      check("rtype_zero", {15'd0, ex_if.Zero}, {15'd0, rexp[i] == 16'h0});
      check("rtype_dest", {13'd0, ex_if.mux_rd_rt_output}, 16'd5);
    end

    // Signed SLT and wrap-around add
    drive(16'hFFFF, 16'h0001, 16'h0006, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 2'b10);
    step();
    check("slt_alu", ex_if.ALU_Result, 16'h0001);
    drive(16'hFFFF, 16'h0001, 16'h0000, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00);
    step();
    check("wrap_alu",  ex_if.ALU_Result, 16'h0000);
    check("wrap_zero", {15'd0, ex_if.Zero}, 16'h1);

    // Negative branch offset
    drive(16'h0001, 16'h0002, 16'hFFFE, 16'h0020, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00);
    step();
    check("negoff_tgt", ex_if.adder_out, 16'h001C);

    // Outputs hold while inputs move between edges
    drive(16'h0005, 16'h0000, 16'h0003, 16'h0000, 3'd2, 3'd7, 1'b0, 1'b1, 2'b00);
    step();
    drive(16'h0100, 16'h0000, 16'h0001, 16'h0000, 3'd4, 3'd6, 1'b1, 1'b1, 2'b00);
    #2;
    check("hold_alu", ex_if.ALU_Result, 16'h0008);
    drive(16'h0005, 16'h0000, 16'h0003, 16'h0000, 3'd2, 3'd7, 1'b0, 1'b1, 2'b00);

    // Async reset between edges
    step();
    check("prerst_alu", ex_if.ALU_Result, 16'h0008);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    step();
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    #1 check_all_zero("rst_release");
    step();
    check("postrst_alu", ex_if.ALU_Result, 16'h0008);

    // Randomized traffic with occasional mid-cycle reset pulses
    for (int n = 0; n < 600; n++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      drive(a, b, 16'($urandom), 16'($urandom), 3'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom), 2'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step();
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
